// File: rtl/iir_out_decim_fifo.sv
// iir_out_decim_fifo: keeps one of every N IIR output samples and buffers the kept
// samples in a first-word-fall-through FIFO with a ready/valid output. The IIR cannot
// be stalled, so kept samples that find the FIFO full are dropped, counted and flagged.
module iir_out_decim_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int DECIM_W    = 4,
    parameter int DROP_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] din,
    input  logic                         din_valid,
    input  logic [DECIM_W-1:0]           decim_factor,
    output logic signed [DATA_WIDTH-1:0] m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    input  logic                         clr_overflow,
    output logic [DROP_W-1:0]            drop_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    // Saturating increment for the dropped-sample counter: sticks at all-ones.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [DECIM_W-1:0] ph_q, ph_d;
    logic               overflow_q, overflow_d;
    logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DECIM_W-1:0] eff_m1;
    logic               kept;
    logic               pop;
    logic               push;
    logic               drop;

    // Decimation keep decision plus FIFO push/pop/drop qualification.
    always_comb begin
        eff_m1 = (decim_factor == '0) ? '0 : decim_factor - DECIM_W'(1);
        kept   = din_valid && (ph_q == '0);
        pop    = (level_q != '0) && m_ready;
        push   = kept && ((level_q < FULL_LVL) || pop);
        drop   = kept && !push;
    end

    // Next-state for phase, pointers, occupancy and overflow bookkeeping.
    always_comb begin
        ph_d       = ph_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        // ">=" rather than "==" so a lowered factor wraps the phase immediately.
        if (din_valid) begin
            ph_d = (ph_q >= eff_m1) ? '0 : ph_q + DECIM_W'(1);
        end

        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end

        // A drop in the same cycle as a clear wins: the clear starts a fresh count.
        if (clr_overflow) begin
            overflow_d = drop;
            drop_cnt_d = drop ? DROP_W'(1) : '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ph_q       <= ph_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Sample storage; data only, so it is never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Fall-through head: zero whenever the FIFO is empty, so reset clears it at once.
    always_comb begin
        m_valid = (level_q != '0);
        m_data  = m_valid ? mem_q[rd_ptr_q] : '0;
    end

    assign level    = level_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule
